// File: rtl/face_dispatch_pkg.sv
// Shared types and constants for the instruction dispatch responder.
package face_dispatch_pkg;

  localparam int unsigned NUM_SLOTS = 4;

  localparam logic [6:0] OPC_SLOT0  = 7'h0B;  // memory-move engine
  localparam logic [6:0] OPC_SLOT1  = 7'h2B;  // SHAKE engine
  localparam logic [6:0] OPC_SLOT2  = 7'h5B;  // systolic engine
  localparam logic [6:0] OPC_SLOT3  = 7'h7B;  // reserved engine
  localparam logic [6:0] NOP_OPCODE = 7'h7F;  // issuer stall bubble (32'hFFFFFFFF)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } slot_state_e;

  typedef struct packed {
    logic [21:0] arg;
    logic [2:0]  func;
    logic [6:0]  opcode;
  } instr_t;

  // Opcode that routes to a given slot index.
  function automatic logic [6:0] slot_opcode(input int unsigned k);
    logic [6:0] opc;
    case (k)
      0:       opc = OPC_SLOT0;
      1:       opc = OPC_SLOT1;
      2:       opc = OPC_SLOT2;
      default: opc = OPC_SLOT3;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/face_dispatch_slot.sv
// One engine slot: tracks a single engine from start pulse to done pulse.
//
// Engine handshake: start_o is high for exactly one cycle when the slot
// leaves IDLE (or re-arms from BUSY); the engine answers with a one-cycle
// done_i, which may coincide with the start cycle. done_i outside
// START/BUSY carries no meaning and is ignored.
module face_dispatch_slot
  import face_dispatch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hit_i,
  input  logic        done_i,
  output logic        start_o,
  output logic        busy_o,
  output logic        collide_o,
  output slot_state_e state_o
);

  slot_state_e state_q;

  assign state_o   = state_q;
  assign start_o   = (state_q == START);
  assign busy_o    = (state_q != IDLE) | hit_i;
  // A hit is dropped unless the slot is idle or finishing this very cycle.
  assign collide_o = hit_i & ((state_q == START) |
                              ((state_q == BUSY) & ~done_i));

  // Slot state machine; a colliding hit never alters the path taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (hit_i) state_q <= START;
        START:   state_q <= done_i ? IDLE : BUSY;
        BUSY: begin
          if (done_i) state_q <= hit_i ? START : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/face_instr_dispatch.sv
// Instruction dispatch responder: decodes one instruction per cycle to one
// of four engine slots, pulses that engine's start and reports per-slot busy.
// Optional build macro: DISPATCH_PERF_EN adds per-slot busy-cycle counters.
module face_instr_dispatch
  import face_dispatch_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [31:0]                    instr,
  output logic [NUM_SLOTS-1:0]           bitbusy,
  output logic [NUM_SLOTS-1:0]           eng_start,
  output logic [2:0]                     eng_func,
  output logic [21:0]                    eng_arg,
  input  logic [NUM_SLOTS-1:0]           eng_done,
  output logic [1:0]                     err
`ifdef DISPATCH_PERF_EN
  ,
  output logic [NUM_SLOTS-1:0][31:0]     perf_busy_cnt
`endif
);

  instr_t                ins;
  logic [NUM_SLOTS-1:0]  hit_raw;
  logic [NUM_SLOTS-1:0]  hit;
  logic [NUM_SLOTS-1:0]  collide;
  logic [NUM_SLOTS-1:0]  accept;
  logic                  unknown;
  slot_state_e           slot_state [NUM_SLOTS];

  logic [2:0]            func_q;
  logic [21:0]           arg_q;
  logic [1:0]            err_q;

  assign ins = instr_t'(instr);

  // Opcode decode; hits are masked during reset so bitbusy reads 0 then.
  always_comb begin
    hit_raw = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      hit_raw[k] = (ins.opcode == slot_opcode(k));
    end
    hit     = rst ? '0 : hit_raw;
    unknown = ~rst & ~(|hit_raw) & (ins.opcode != NOP_OPCODE);
  end

  // An instruction is taken when its slot is idle or re-arming on done.
  always_comb begin
    accept = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      accept[k] = hit[k] & ((slot_state[k] == IDLE) |
                            ((slot_state[k] == BUSY) & eng_done[k]));
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    face_dispatch_slot u_slot (
      .clk_i     (clk),
      .rst_i     (rst),
      .hit_i     (hit[g]),
      .done_i    (eng_done[g]),
      .start_o   (eng_start[g]),
      .busy_o    (bitbusy[g]),
      .collide_o (collide[g]),
      .state_o   (slot_state[g])
    );
  end

  // Operand capture for the most recently accepted instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_q <= '0;
      arg_q  <= '0;
    end else if (|accept) begin
      func_q <= ins.func;
      arg_q  <= ins.arg;
    end
  end

  // Sticky error flags: [0] collision, [1] unknown opcode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | {unknown, |collide};
    end
  end

  assign eng_func = func_q;
  assign eng_arg  = arg_q;
  assign err      = err_q;

`ifdef DISPATCH_PERF_EN
  logic [NUM_SLOTS-1:0][31:0] perf_q;

  // Saturating count of cycles each slot spends outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if ((slot_state[k] != IDLE) && (perf_q[k] != 32'hFFFF_FFFF)) begin
          perf_q[k] <= perf_q[k] + 32'd1;
        end
      end
    end
  end

  assign perf_busy_cnt = perf_q;
`endif

endmodule

// File: tb/tb_face_instr_dispatch.sv
// Self-checking bench for face_instr_dispatch (directed vectors, scoreboard
// of expected start pulses with their func/arg).
module tb_face_instr_dispatch;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [3:0]  bitbusy;
  logic [3:0]  eng_start;
  logic [2:0]  eng_func;
  logic [21:0] eng_arg;
  logic [3:0]  eng_done;
  logic [1:0]  err;
`ifdef DISPATCH_PERF_EN
  logic [3:0][31:0] perf_busy_cnt;
`endif

  localparam logic [31:0] BUBBLE = 32'hFFFF_FFFF;

  int checks = 0;
  int errors = 0;

  // Expected start events: {start[3:0], func[2:0], arg[21:0]}
  logic [28:0] exp_q[$];

  face_instr_dispatch dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .bitbusy   (bitbusy),
    .eng_start (eng_start),
    .eng_func  (eng_func),
    .eng_arg   (eng_arg),
    .eng_done  (eng_done),
    .err       (err)
`ifdef DISPATCH_PERF_EN
    ,
    .perf_busy_cnt (perf_busy_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] fn,
                                     input logic [21:0] a);
    return {a, fn, opc};
  endfunction

  // Present an instruction expected to be accepted; its start is queued.
  task automatic issue(input logic [6:0] opc, input logic [2:0] fn,
                       input logic [21:0] a, input logic [3:0] slot_mask);
    instr = mk(opc, fn, a);
    exp_q.push_back({slot_mask, fn, a});
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && eng_start != 4'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected: actual=%b required=none at %0t", eng_start, $time);
      end else begin
        logic [28:0] e;
        e = exp_q.pop_front();
        if ({eng_start, eng_func, eng_arg} !== e) begin
          errors++;
          $display("FAIL start_event: actual=%b/%0d/%h required=%b/%0d/%h at %0t",
                   eng_start, eng_func, eng_arg, e[28:25], e[24:22], e[21:0], $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    instr    = 32'h0000_005B;
    eng_done = 4'b0;

    // Reset held 3 cycles with a slot-2 opcode present.
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_bitbusy", {28'd0, bitbusy}, 32'd0);
      check("rst_start",   {28'd0, eng_start}, 32'd0);
      check("rst_err",     {30'd0, err}, 32'd0);
      step();
    end
    instr = BUBBLE;
    rst   = 1'b0;
    step();

    // Single dispatch to slot 2, done six cycles later.
    issue(7'h5B, 3'd5, 22'h1234, 4'b0100);
    #1 check("single_busy_N", {28'd0, bitbusy}, 32'h4);
    step();                                   // N+1: START
    instr = BUBBLE;
    check("single_start", {28'd0, eng_start}, 32'h4);
    check("single_func",  {29'd0, eng_func}, 32'd5);
    check("single_arg",   {10'd0, eng_arg}, 32'h1234);
    for (int i = 0; i < 5; i++) step();       // N+6
    eng_done = 4'b0100;
    #1 check("single_busy_done", {28'd0, bitbusy}, 32'h4);
    step();                                   // N+7
    eng_done = 4'b0;
    #1 check("single_idle", {28'd0, bitbusy}, 32'h0);
`ifdef DISPATCH_PERF_EN
    check("perf_slot2", perf_busy_cnt[2], 32'd6);
`endif

    // Back-to-back on slot 1: done plus new instruction in N+4.
    issue(7'h2B, 3'd1, 22'h00AA, 4'b0010);
    step();
    instr = BUBBLE;
    step();
    step();
    step();                                   // N+4
    issue(7'h2B, 3'd2, 22'h00BB, 4'b0010);
    eng_done = 4'b0010;
    #1 check("b2b_busy", {28'd0, bitbusy}, 32'h2);
    step();                                   // N+5
    instr    = BUBBLE;
    eng_done = 4'b0;
    check("b2b_start", {28'd0, eng_start}, 32'h2);
    check("b2b_err",   {30'd0, err}, 32'd0);
    step();                                   // N+6: BUSY
    eng_done = 4'b0010;
    step();
    eng_done = 4'b0;
    #1 check("b2b_idle", {28'd0, bitbusy}, 32'h0);

    // Collision on slot 1: second instruction dropped.
    issue(7'h2B, 3'd3, 22'h0111, 4'b0010);
    step();
    instr = BUBBLE;
    step();                                   // N+2
    instr = mk(7'h2B, 3'd4, 22'h0222);
    step();                                   // N+3
    instr = BUBBLE;
    check("coll_err",  {30'd0, err}, 32'h1);
    check("coll_arg",  {10'd0, eng_arg}, 32'h0111);
    check("coll_func", {29'd0, eng_func}, 32'd3);
    check("coll_nostart", {28'd0, eng_start}, 32'h0);
    eng_done = 4'b0010;
    step();
    eng_done = 4'b0;
    #1 check("coll_idle", {28'd0, bitbusy}, 32'h0);

    // Bubbles: nothing changes.
    for (int i = 0; i < 5; i++) begin
      instr = BUBBLE;
      step();
      check("bubble_busy", {28'd0, bitbusy}, 32'h0);
      check("bubble_err",  {30'd0, err}, 32'h1);
    end

    // Unknown opcode.
    instr = 32'h0000_0013;
    #1 check("unk_busy", {28'd0, bitbusy}, 32'h0);
    step();
    instr = BUBBLE;
    check("unk_err",  {30'd0, err}, 32'h3);
    check("unk_busy_after", {28'd0, bitbusy}, 32'h0);

    // Concurrency, then reset while both slots are busy.
    issue(7'h2B, 3'd6, 22'h0005, 4'b0010);
    step();
    issue(7'h5B, 3'd7, 22'h0006, 4'b0100);
    step();
    instr = BUBBLE;
    step();
    check("conc_busy", {28'd0, bitbusy}, 32'h6);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {28'd0, bitbusy}, 32'h0);
    check("async_rst_err",  {30'd0, err}, 32'h0);
    check("async_rst_arg",  {10'd0, eng_arg}, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_busy",  {28'd0, bitbusy}, 32'h0);
    check("post_rst_start", {28'd0, eng_start}, 32'h0);
`ifdef DISPATCH_PERF_EN
    for (int k = 0; k < 4; k++) check("perf_rst", perf_busy_cnt[k], 32'd0);
`endif
    step();
    step();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/face_instr_dispatch.md
Name: face_instr_dispatch

Overview:
- Accelerator-side responder to the instruction issue interface.
- Each cycle it accepts one 32-bit instruction from the issuer's execute stage and decodes its opcode to one of four engine slots.
- It issues a start pulse with func/operand to that engine, then tracks the engine until its done pulse.
- It reports the per-slot `bitbusy[3:0]` vector that the issuer uses to stall same-type instructions.

Parameters:
- OPC_SLOT0, 7'h0B, opcode routed to slot 0 (memory-move engine)
- OPC_SLOT1, 7'h2B, opcode routed to slot 1 (SHAKE engine)
- OPC_SLOT2, 7'h5B, opcode routed to slot 2 (systolic engine)
- OPC_SLOT3, 7'h7B, opcode routed to slot 3 (reserved engine)
- NOP_OPCODE, 7'h7F, bubble opcode; the issuer's stall bubble 32'hFFFFFFFF decodes to this

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- instr  in  32  instruction from issuer; [6:0] opcode, [9:7] func, [31:10] arg
- bitbusy  out  4  per-slot busy to issuer
- eng_start  out  4  one-cycle start pulse per slot
- eng_func  out  3  func field of last dispatched instruction (registered)
- eng_arg  out  22  arg field of last dispatched instruction (registered)
- eng_done  in  4  one-cycle completion pulse per slot
- err  out  2  sticky: [0] collision (instr to busy slot), [1] unknown opcode

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. While rst is high and on its release, all outputs are 0 and all slots are IDLE.
- Decode is combinational on `instr`. `hit[k]` = (opcode == OPC_SLOTk). Opcode NOP_OPCODE is a no-op: no error, no state change.
- Per-slot FSM:
  - IDLE: on `hit[k]` go to START, and latch func/arg into eng_func/eng_arg.
  - START: eng_start[k]=1 for exactly this cycle. If eng_done[k] is also high, go to IDLE; otherwise go to BUSY.
  - BUSY: on eng_done[k], go to IDLE, unless `hit[k]` in the same cycle, in which case go to START (back-to-back, no idle gap).
- Latency: instruction presented in cycle N gives eng_start[k] in N+1. Minimum slot turnaround is 2 cycles (START then IDLE).
- bitbusy[k] = (state != IDLE) | hit[k], combinational. This makes the slot busy in the very cycle its instruction is presented, so the issuer cannot push a second same-slot instruction through its decode-to-execute skid.
- Collision: `hit[k]` while in START, or while in BUSY without eng_done[k] → drop the instruction, set err[0], leave state and eng_func/eng_arg untouched.
- Unknown opcode (no hit, not NOP) → set err[1], ignore.
- err bits clear only on rst.
- Multiple slots may be busy concurrently. Only one instruction arrives per cycle, so there is at most one start per cycle.
- eng_done[k] while IDLE is ignored.
- Reset mid-operation: all FSMs go to IDLE immediately, and in-flight engines are abandoned (engines are reset by the same rst).

Optional Feature:
- DISPATCH_PERF_EN defined: adds output `perf_busy_cnt` [4][31:0].
  - Per-slot counter increments every cycle that slot state != IDLE.
  - Counters saturate at 32'hFFFFFFFF and reset to 0 on rst.
- Undefined: the port and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package face_dispatch_pkg holds:
  - slot state enum {IDLE, START, BUSY}
  - packed struct instr_t {arg[21:0], func[2:0], opcode[6:0]}
  - NUM_SLOTS=4
  - NOP_OPCODE constant
- Sub-module face_dispatch_slot is instantiated 4 times. It contains one FSM: inputs hit, done; outputs start, busy, collide.
- The top level owns decode, the func/arg registers, err, and the perf counters.

Test Plan:
- Reset: hold rst=1 for 3 cycles while instr=32'h0000005B → bitbusy=0, eng_start=0, err=0 throughout.
- Single dispatch: instr={arg=22'h1234, func=3'd5, opcode=7'h5B} in cycle N → bitbusy[2]=1 in N, eng_start=4'b0100 in N+1, eng_func=5, eng_arg=22'h1234. With eng_done[2] in N+6, bitbusy[2]=0 in N+7.
- Back-to-back: SHAKE (7'h2B) in N, eng_done[1] together with a new 7'h2B in N+4 → eng_start[1] in N+5, no idle cycle, err=0.
- Collision: 7'h2B in N, again 7'h2B in N+2 with no done → err[0]=1, exactly one eng_start pulse, eng_arg holds the first value.
- Bubble and unknown: 32'hFFFFFFFF for 5 cycles → no change. Then opcode 7'h13 → err[1]=1, bitbusy unchanged.
- Concurrency and reset: start slots 1 and 2, then assert rst while both are BUSY → bitbusy=0 asynchronously. After release, perf_busy_cnt=0 (DISPATCH_PERF_EN build).
